lift_call_sched: RTL and testbench

LIFT_CALL_SCHED -- requirements
Module: lift_call_sched

---
 rtl/lift_call_sched.sv | 167 ++++++++++++++++
 tb/tb_lift_call_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_call_sched.sv
// lift_call_sched: four-floor lift call scheduler.
// Latches hall/car calls, sweeps the cab up or down toward outstanding calls,
// and holds the door open for a configurable dwell. A same-floor call during
// the dwell restarts it.
// Optional build macro LIFT_CALL_SCHED_KEY_LOCK_EN adds input keyinput0 and a
// short-dwell door state S_DOOR_D, entered instead of S_DOOR when keyinput0=0.
module lift_call_sched #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
`ifdef LIFT_CALL_SCHED_KEY_LOCK_EN
  input  logic       keyinput0,
`endif
  input  logic [3:0] call,
  input  logic [1:0] cur_floor,
  input  logic       at_floor,
  input  logic       door_closed,
  output logic       move_up,
  output logic       move_down,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       dir_up
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP     = 3'd1,
    S_DOWN   = 3'd2,
    S_DOOR   = 3'd3,
`ifdef LIFT_CALL_SCHED_KEY_LOCK_EN
    S_DOOR_D = 3'd5,
`endif
    S_CLOSE  = 3'd4
  } state_e;

  localparam logic [3:0] DWELL_FULL  = 4'(DOOR_CYCLES - 1);
  localparam logic [3:0] DWELL_SHORT = 4'd1;

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic       dir_up_q, dir_up_d;
  logic [3:0] dwell_q, dwell_d;

  logic [3:0] floor_oh;
  logic [3:0] mask_above;
  logic [3:0] mask_below;
  logic       any_above;
  logic       any_below;
  logic       enter_door;
  logic [3:0] call_mask;
  state_e     door_state;
  logic [3:0] door_load;

  // Floor-relative views of the latched calls.
  always_comb begin
    floor_oh   = 4'b0001 << cur_floor;
    mask_above = ~((floor_oh << 1) - 4'd1);
    mask_below = floor_oh - 4'd1;
    any_above  = |(pending_q & mask_above);
    any_below  = |(pending_q & mask_below);
  end

  // Pick which door state a door entry lands in, and the dwell it loads.
  always_comb begin
`ifdef LIFT_CALL_SCHED_KEY_LOCK_EN
    door_state = keyinput0 ? S_DOOR : S_DOOR_D;
    door_load  = keyinput0 ? DWELL_FULL : DWELL_SHORT;
`else
    door_state = S_DOOR;
    door_load  = DWELL_FULL;
`endif
  end

  // Next-state, dwell, direction, call latching and Moore outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    dir_up_d   = dir_up_q;
    dwell_d    = dwell_q;
    enter_door = 1'b0;
    call_mask  = 4'b1111;
    move_up    = 1'b0;
    move_down  = 1'b0;
    door_open  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q[cur_floor]) begin
          enter_door = 1'b1;
        end else if (|pending_q) begin
          if (any_above && (dir_up_q || !any_below)) begin
            state_d  = S_UP;
            dir_up_d = 1'b1;
          end else begin
            state_d  = S_DOWN;
            dir_up_d = 1'b0;
          end
        end
      end
      S_UP: begin
        move_up = 1'b1;
        if (at_floor) begin
          if (pending_q[cur_floor])  enter_door = 1'b1;
          else if (cur_floor == 2'd3) state_d    = S_IDLE;
        end
      end
      S_DOWN: begin
        move_down = 1'b1;
        if (at_floor) begin
          if (pending_q[cur_floor])  enter_door = 1'b1;
          else if (cur_floor == 2'd0) state_d    = S_IDLE;
        end
      end
      S_DOOR: begin
        door_open = 1'b1;
        // A call at the open door extends the dwell instead of queueing.
        call_mask = ~floor_oh;
        if (call[cur_floor])     dwell_d = DWELL_FULL;
        else if (dwell_q == '0)  state_d = S_CLOSE;
        else                     dwell_d = dwell_q - 4'd1;
      end
`ifdef LIFT_CALL_SCHED_KEY_LOCK_EN
      S_DOOR_D: begin
        door_open = 1'b1;
        call_mask = ~floor_oh;
        if (call[cur_floor])     dwell_d = DWELL_SHORT;
        else if (dwell_q == '0)  state_d = S_CLOSE;
        else                     dwell_d = dwell_q - 4'd1;
      end
`endif
      S_CLOSE: begin
        if (call[cur_floor]) enter_door = 1'b1;
        else if (door_closed) state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_door) begin
      state_d = door_state;
      dwell_d = door_load;
    end

    // The floor being served is cleared on door entry, beating a same-edge call.
    pending_d = (pending_q | (call & call_mask)) & ~(enter_door ? floor_oh : 4'b0000);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      dir_up_q  <= 1'b1;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dir_up_q  <= dir_up_d;
      dwell_q   <= dwell_d;
    end
  end

  assign pending = pending_q;
  assign dir_up  = dir_up_q;

endmodule

// File: tb/tb_lift_call_sched.sv
// Directed testbench for lift_call_sched. Observed outputs are packed as
// {move_up, move_down, door_open, dir_up, pending[3:0]} and compared to
// hand-computed values one cycle at a time.
module tb_lift_call_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyinput0;
  logic [3:0] call;
  logic [1:0] cur_floor;
  logic       at_floor;
  logic       door_closed;
  logic       move_up;
  logic       move_down;
  logic       door_open;
  logic [3:0] pending;
  logic       dir_up;

  int checks   = 0;
  int failures = 0;

  logic [7:0] obs;
  logic [7:0] exp;
  assign obs = {move_up, move_down, door_open, dir_up, pending};

  lift_call_sched #(.DOOR_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef LIFT_CALL_SCHED_KEY_LOCK_EN
    .keyinput0  (keyinput0),
`endif
    .call       (call),
    .cur_floor  (cur_floor),
    .at_floor   (at_floor),
    .door_closed(door_closed),
    .move_up    (move_up),
    .move_down  (move_down),
    .door_open  (door_open),
    .pending    (pending),
    .dir_up     (dir_up)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] f, input logic a, input logic d);
    call        = c;
    cur_floor   = f;
    at_floor    = a;
    door_closed = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(4'b1111, 2'd0, 1'b1, 1'b1);
    tick(); tick();
    exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL reset_state: got %02h expected %02h", obs, exp); end
    checks++;
    rst = 1'b1;
    call = 4'b0000;
  endtask

  task automatic test_same_floor();
    drive(4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); exp = 8'h11;
    if (obs !== exp) begin failures++; $display("FAIL sf_latch: got %02h expected %02h", obs, exp); end
    checks++;
    call = 4'b0000;
    tick(); exp = 8'h30;
    if (obs !== exp) begin failures++; $display("FAIL sf_door_open: got %02h expected %02h", obs, exp); end
    checks++;
    for (int i = 1; i < 8; i++) begin
      tick(); exp = 8'h30;
      if (obs !== exp) begin failures++; $display("FAIL sf_dwell cycle %0d: got %02h expected %02h", i, obs, exp); end
      checks++;
    end
    tick(); exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL sf_close: got %02h expected %02h", obs, exp); end
    checks++;
    tick(); tick();
    // Still in CLOSE (door not closed): a same-floor call reopens immediately.
    call = 4'b0001;
    tick(); exp = 8'h30;
    if (obs !== exp) begin failures++; $display("FAIL sf_close_reopen: got %02h expected %02h", obs, exp); end
    checks++;
    call = 4'b0000;
    door_closed = 1'b1;
    for (int i = 1; i < 8; i++) tick();
    tick(); exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL sf_reclose: got %02h expected %02h", obs, exp); end
    checks++;
    tick();
  endtask

  task automatic test_up_sweep();
    drive(4'b1000, 2'd0, 1'b1, 1'b1);
    tick(); exp = 8'h18;
    if (obs !== exp) begin failures++; $display("FAIL up_latch: got %02h expected %02h", obs, exp); end
    checks++;
    call = 4'b0000;
    tick(); exp = 8'h98;
    if (obs !== exp) begin failures++; $display("FAIL up_start: got %02h expected %02h", obs, exp); end
    checks++;
    for (int f = 1; f < 3; f++) begin
      cur_floor = 2'(f);
      tick(); exp = 8'h98;
      if (obs !== exp) begin failures++; $display("FAIL up_pass floor %0d: got %02h expected %02h", f, obs, exp); end
      checks++;
    end
    drive(4'b0000, 2'd3, 1'b0, 1'b1);
    tick(); exp = 8'h98;
    if (obs !== exp) begin failures++; $display("FAIL up_not_aligned: got %02h expected %02h", obs, exp); end
    checks++;
    at_floor = 1'b1;
    tick(); exp = 8'h30;
    if (obs !== exp) begin failures++; $display("FAIL up_top_door: got %02h expected %02h", obs, exp); end
    checks++;
    for (int i = 1; i < 8; i++) tick();
    tick(); exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL up_close: got %02h expected %02h", obs, exp); end
    checks++;
    tick();
  endtask

  task automatic test_reversal();
    drive(4'b1001, 2'd1, 1'b1, 1'b1);
    tick(); exp = 8'h19;
    if (obs !== exp) begin failures++; $display("FAIL rev_latch: got %02h expected %02h", obs, exp); end
    checks++;
    call = 4'b0000;
    tick(); exp = 8'h99;
    if (obs !== exp) begin failures++; $display("FAIL rev_up: got %02h expected %02h", obs, exp); end
    checks++;
    cur_floor = 2'd2;
    tick();
    cur_floor = 2'd3;
    tick(); exp = 8'h31;
    if (obs !== exp) begin failures++; $display("FAIL rev_serve_top: got %02h expected %02h", obs, exp); end
    checks++;
    for (int i = 1; i < 8; i++) tick();
    tick(); exp = 8'h11;
    if (obs !== exp) begin failures++; $display("FAIL rev_close_top: got %02h expected %02h", obs, exp); end
    checks++;
    tick();
    tick(); exp = 8'h41;
    if (obs !== exp) begin failures++; $display("FAIL rev_down: got %02h expected %02h", obs, exp); end
    checks++;
    cur_floor = 2'd2; tick();
    cur_floor = 2'd1; tick(); exp = 8'h41;
    if (obs !== exp) begin failures++; $display("FAIL rev_down_pass: got %02h expected %02h", obs, exp); end
    checks++;
    cur_floor = 2'd0;
    tick(); exp = 8'h20;
    if (obs !== exp) begin failures++; $display("FAIL rev_serve_bottom: got %02h expected %02h", obs, exp); end
    checks++;
    for (int i = 1; i < 8; i++) tick();
    tick(); tick();
  endtask

  task automatic test_dwell_reload();
    drive(4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); exp = 8'h02;
    if (obs !== exp) begin failures++; $display("FAIL rl_latch: got %02h expected %02h", obs, exp); end
    checks++;
    call = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) tick();
    call = 4'b0010;
    tick(); exp = 8'h20;
    if (obs !== exp) begin failures++; $display("FAIL rl_no_latch: got %02h expected %02h", obs, exp); end
    checks++;
    call = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      tick(); exp = 8'h20;
      if (obs !== exp) begin failures++; $display("FAIL rl_hold cycle %0d: got %02h expected %02h", i, obs, exp); end
      checks++;
    end
    tick(); exp = 8'h00;
    if (obs !== exp) begin failures++; $display("FAIL rl_close: got %02h expected %02h", obs, exp); end
    checks++;
    for (int i = 0; i < 9; i++) tick();
  endtask

  task automatic test_dir_pref();
    drive(4'b1001, 2'd1, 1'b1, 1'b1);
    tick();
    call = 4'b0000;
    tick(); exp = 8'h49;
    if (obs !== exp) begin failures++; $display("FAIL dir_keep_down: got %02h expected %02h", obs, exp); end
    checks++;
    cur_floor = 2'd0;
    tick(); exp = 8'h28;
    if (obs !== exp) begin failures++; $display("FAIL dir_serve_bottom: got %02h expected %02h", obs, exp); end
    checks++;
    for (int i = 1; i < 8; i++) tick();
    tick(); tick();
    tick(); exp = 8'h98;
    if (obs !== exp) begin failures++; $display("FAIL dir_turn_up: got %02h expected %02h", obs, exp); end
    checks++;
    cur_floor = 2'd1; tick();
    cur_floor = 2'd2; tick();
    cur_floor = 2'd3;
    tick(); exp = 8'h30;
    if (obs !== exp) begin failures++; $display("FAIL dir_serve_top: got %02h expected %02h", obs, exp); end
    checks++;
    for (int i = 1; i < 8; i++) tick();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    drive(4'b1000, 2'd1, 1'b1, 1'b1);
    tick();
    call = 4'b0000;
    tick(); exp = 8'h98;
    if (obs !== exp) begin failures++; $display("FAIL rm_moving: got %02h expected %02h", obs, exp); end
    checks++;
    rst = 1'b0;
    tick(); exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL rm_mid_move: got %02h expected %02h", obs, exp); end
    checks++;
    rst = 1'b1;
    call = 4'b0010;
    tick();
    call = 4'b0000;
    tick(); tick(); exp = 8'h30;
    if (obs !== exp) begin failures++; $display("FAIL rm_dwelling: got %02h expected %02h", obs, exp); end
    checks++;
    rst = 1'b0;
    tick(); exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL rm_mid_dwell: got %02h expected %02h", obs, exp); end
    checks++;
    rst = 1'b1;
    tick(); exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL rm_release: got %02h expected %02h", obs, exp); end
    checks++;
  endtask

`ifdef LIFT_CALL_SCHED_KEY_LOCK_EN
  task automatic test_key_lock();
    keyinput0 = 1'b0;
    drive(4'b0001, 2'd0, 1'b1, 1'b1);
    tick();
    call = 4'b0000;
    tick(); exp = 8'h30;
    if (obs !== exp) begin failures++; $display("FAIL kl_open: got %02h expected %02h", obs, exp); end
    checks++;
    tick(); exp = 8'h30;
    if (obs !== exp) begin failures++; $display("FAIL kl_hold: got %02h expected %02h", obs, exp); end
    checks++;
    tick(); exp = 8'h10;
    if (obs !== exp) begin failures++; $display("FAIL kl_short_close: got %02h expected %02h", obs, exp); end
    checks++;
    tick();
    keyinput0 = 1'b1;
  endtask
`endif

  initial begin
    rst       = 1'b0;
    keyinput0 = 1'b1;
    drive(4'b0000, 2'd0, 1'b1, 1'b1);
    test_reset();
    test_same_floor();
    test_up_sweep();
    test_reversal();
    test_dwell_reload();
    test_dir_pref();
    test_reset_mid();
`ifdef LIFT_CALL_SCHED_KEY_LOCK_EN
    test_key_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
